// File: rtl/lookup_table_mc_if.sv
// Bus bundle for lookup_table_mc: GPIO programming port plus the per-channel lookup ports.
interface lookup_table_mc_if #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned IN_BITS  = 10,
    parameter int unsigned OUT_BITS = 16
);
    logic [31:0]                gpio_in;
    logic [NUM_CH*IN_BITS-1:0]  val_in;
    logic [NUM_CH-1:0]          val_in_valid;
    logic [NUM_CH*OUT_BITS-1:0] val_out;
    logic [NUM_CH-1:0]          val_out_valid;
    logic                       active_bank;

    // Host / datapath side: drives programming and lookup requests
    modport master (
        output gpio_in,
        output val_in,
        output val_in_valid,
        input  val_out,
        input  val_out_valid,
        input  active_bank
    );

    // LUT side
    modport slave (
        input  gpio_in,
        input  val_in,
        input  val_in_valid,
        output val_out,
        output val_out_valid,
        output active_bank
    );
endinterface

// File: rtl/lookup_table_mc.sv
// Multi-channel ping-pong lookup table programmed over GPIO.
// GPIO layout: bit 31 = w_clk strobe, [15:8] = register address, [7:0] = data byte.
// Writes always land in the shadow bank (!active_bank); lookups read the bank
// captured alongside the lookup address, so a swap never disturbs in-flight reads.
module lookup_table_mc #(
    parameter int unsigned ADDR_REG   = 0,
    parameter int unsigned DATA_REG   = 1,
    parameter int unsigned CTRL_REG   = 2,
    parameter int unsigned CHMASK_REG = 3,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned IN_BITS    = 10,
    parameter int unsigned OUT_BITS   = 16
) (
    input  logic               clk,
    input  logic               rst,
    lookup_table_mc_if.slave   bus
);

    localparam int unsigned DB        = (OUT_BITS + 7) / 8;
    localparam int unsigned ACC_W     = DB * 8;
    localparam int unsigned CNT_W     = (DB > 1) ? $clog2(DB) : 1;
    localparam int unsigned DEPTH     = 1 << IN_BITS;
    localparam int unsigned WCLK_BIT  = 31;
    localparam int unsigned RADDR_LSB = 8;
    localparam int unsigned RDATA_LSB = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    logic [1:0] rst_sync;
    logic       rst_n;

    logic       w_clk_c;
    logic [7:0] reg_addr_c;
    logic [7:0] reg_data_c;
    logic       gpio_unused_c;

    state_t state_q;
    state_t state_d;
    logic   access_c;

    logic [IN_BITS-1:0] wr_addr_q;
    logic [IN_BITS-1:0] wr_addr_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [ACC_W-1:0]   acc_shift_c;
    logic [NUM_CH-1:0]  chmask_q;
    logic [NUM_CH-1:0]  chmask_d;
    logic               bank_q;
    logic               bank_d;
    logic               commit_c;
    logic [OUT_BITS-1:0] commit_data_c;

    // Reset synchroniser: asserts immediately, releases on the second clock
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    assign w_clk_c       = bus.gpio_in[WCLK_BIT];
    assign reg_addr_c    = bus.gpio_in[RADDR_LSB +: 8];
    assign reg_data_c    = bus.gpio_in[RDATA_LSB +: 8];
    assign gpio_unused_c = ^bus.gpio_in[30:16];

    assign acc_shift_c   = ACC_W'({acc_q, reg_data_c});
    assign commit_data_c = acc_shift_c[OUT_BITS-1:0];

    // Handshake state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // One register access per w_clk high pulse; wait for w_clk low before re-arming
    always_comb begin
        state_d  = state_q;
        access_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_clk_c) begin
                    access_c = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!w_clk_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register-file decode: address shift, word assembly, commands, channel mask
    always_comb begin
        wr_addr_d = wr_addr_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        chmask_d  = chmask_q;
        bank_d    = bank_q;
        commit_c  = 1'b0;
        if (access_c) begin
            if (reg_addr_c == 8'(ADDR_REG)) begin
                wr_addr_d = IN_BITS'({wr_addr_q, reg_data_c});
                cnt_d     = '0;
            end else if (reg_addr_c == 8'(DATA_REG)) begin
                acc_d = acc_shift_c;
                if (cnt_q == CNT_W'(DB - 1)) begin
                    commit_c  = 1'b1;
                    wr_addr_d = wr_addr_q + IN_BITS'(1);
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (reg_addr_c == 8'(CTRL_REG)) begin
                if (reg_data_c[0]) begin
                    bank_d = ~bank_q;
                    cnt_d  = '0;
                end
                if (reg_data_c[1]) begin
                    wr_addr_d = '0;
                    cnt_d     = '0;
                end
            end else if (reg_addr_c == 8'(CHMASK_REG)) begin
                chmask_d = reg_data_c[NUM_CH-1:0];
            end
        end
    end

    // Programming state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            chmask_q  <= '1;
            bank_q    <= 1'b0;
        end else begin
            wr_addr_q <= wr_addr_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            chmask_q  <= chmask_d;
            bank_q    <= bank_d;
        end
    end

    assign bus.active_bank = bank_q;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [OUT_BITS-1:0] mem [2*DEPTH];
        logic                s1_valid;
        logic [IN_BITS-1:0]  s1_addr;
        logic                s1_bank;
        logic [OUT_BITS-1:0] out_q;
        logic                out_valid;

        // Shadow-bank write for enabled channels; contents are not reset
        always_ff @(posedge clk) begin
            if (commit_c && chmask_q[ch]) begin
                mem[{~bank_q, wr_addr_q}] <= commit_data_c;
            end
        end

        // Stage 1: capture lookup address together with the bank serving it
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid <= 1'b0;
                s1_addr  <= '0;
                s1_bank  <= 1'b0;
            end else begin
                s1_valid <= bus.val_in_valid[ch];
                if (bus.val_in_valid[ch]) begin
                    s1_addr <= bus.val_in[ch*IN_BITS +: IN_BITS];
                    s1_bank <= bank_q;
                end
            end
        end

        // Stage 2: registered read; data holds when no lookup is in flight
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q     <= '0;
                out_valid <= 1'b0;
            end else begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_q <= mem[{s1_bank, s1_addr}];
                end
            end
        end

        assign bus.val_out[ch*OUT_BITS +: OUT_BITS] = out_q;
        assign bus.val_out_valid[ch]                = out_valid;
    end

endmodule

// File: tb/tb_lookup_table_mc.sv
// Bench for lookup_table_mc: directed GPIO programming, lookups scored through a queue.
module tb_lookup_table_mc;

    localparam int unsigned NUM_CH   = 2;
    localparam int unsigned IN_BITS  = 10;
    localparam int unsigned OUT_BITS = 16;

    localparam logic [7:0] R_ADDR = 8'd0;
    localparam logic [7:0] R_DATA = 8'd1;
    localparam logic [7:0] R_CTRL = 8'd2;
    localparam logic [7:0] R_MASK = 8'd3;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q0[$];
    exp_t q1[$];

    lookup_table_mc_if #(.NUM_CH(NUM_CH), .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) bus ();

    lookup_table_mc #(
        .NUM_CH  (NUM_CH),
        .IN_BITS (IN_BITS),
        .OUT_BITS(OUT_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gpio_wr(input logic [7:0] a, input logic [7:0] d, input int hold);
        bus.gpio_in = {1'b1, 15'd0, a, d};
        repeat (hold) tick();
        bus.gpio_in = {1'b0, 15'd0, a, d};
        repeat (2) tick();
    endtask

    task automatic push_exp(input int ch, input logic [15:0] d);
        exp_t e;
        e.data = d;
        e.cyc  = cyc + 2;
        if (ch == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    task automatic lookup(input int ch, input logic [9:0] a, input logic [15:0] d);
        bus.val_in[ch*IN_BITS +: IN_BITS] = a;
        bus.val_in_valid[ch] = 1'b1;
        push_exp(ch, d);
        tick();
        bus.val_in_valid[ch] = 1'b0;
        repeat (3) tick();
    endtask

    // Monitor: every presented result must match the queue head at the expected cycle
    always @(negedge clk) begin
        exp_t        e;
        logic        got;
        logic [15:0] act;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                got = 1'b0;
                e.data = '0;
                e.cyc  = 0;
                if (c == 0 && q0.size() > 0 && (bus.val_out_valid[0] || q0[0].cyc < cyc)) begin
                    e = q0.pop_front();
                    got = 1'b1;
                end else if (c == 1 && q1.size() > 0 && (bus.val_out_valid[1] || q1[0].cyc < cyc)) begin
                    e = q1.pop_front();
                    got = 1'b1;
                end
                act = bus.val_out[c*OUT_BITS +: OUT_BITS];
                if (bus.val_out_valid[c] && !got) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid ch%0d: got 0x%0h at cycle %0d, expected no output", c, act, cyc);
                end else if (got) begin
                    checks++;
                    if (!bus.val_out_valid[c] || act !== e.data || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL lookup ch%0d: got valid=%0b data=0x%0h cycle=%0d, expected data=0x%0h cycle=%0d",
                                 c, bus.val_out_valid[c], act, cyc, e.data, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        bus.gpio_in      = '0;
        bus.val_in       = '0;
        bus.val_in_valid = '0;
        rst              = 1'b0;
        repeat (3) tick();
        check("reset_active_bank", 32'(bus.active_bank), 32'd0);
        check("reset_out_valid", 32'(bus.val_out_valid), 32'd0);
        check("reset_val_out", 32'(bus.val_out), 32'd0);
        rst = 1'b1;
        repeat (3) tick();

        // Basic program + swap: bank1[0x123] = 0xBEEF
        gpio_wr(R_ADDR, 8'h01, 1);
        gpio_wr(R_ADDR, 8'h23, 1);
        gpio_wr(R_DATA, 8'hBE, 1);
        gpio_wr(R_DATA, 8'hEF, 1);
        gpio_wr(R_CTRL, 8'h01, 1);
        check("swap1_active_bank", 32'(bus.active_bank), 32'd1);
        lookup(0, 10'h123, 16'hBEEF);
        lookup(1, 10'h123, 16'hBEEF);

        // Auto-increment with wrap: bank0[0x3FF]=0x1122, bank0[0x000]=0x3344
        gpio_wr(R_ADDR, 8'h03, 1);
        gpio_wr(R_ADDR, 8'hFF, 1);
        gpio_wr(R_DATA, 8'h11, 1);
        gpio_wr(R_DATA, 8'h22, 1);
        gpio_wr(R_DATA, 8'h33, 1);
        gpio_wr(R_DATA, 8'h44, 1);
        gpio_wr(R_CTRL, 8'h01, 1);
        check("swap2_active_bank", 32'(bus.active_bank), 32'd0);
        lookup(0, 10'h3FF, 16'h1122);
        lookup(1, 10'h000, 16'h3344);

        // Channel mask: preload 0x5555 in both channels, then 0xAAAA to ch1 only
        gpio_wr(R_CTRL, 8'h02, 1);
        gpio_wr(R_ADDR, 8'h10, 1);
        gpio_wr(R_DATA, 8'h55, 1);
        gpio_wr(R_DATA, 8'h55, 1);
        gpio_wr(R_MASK, 8'h02, 1);
        gpio_wr(R_ADDR, 8'h00, 1);
        gpio_wr(R_ADDR, 8'h10, 1);
        gpio_wr(R_DATA, 8'hAA, 1);
        gpio_wr(R_DATA, 8'hAA, 1);
        gpio_wr(R_CTRL, 8'h01, 1);
        check("swap3_active_bank", 32'(bus.active_bank), 32'd1);
        lookup(0, 10'h010, 16'h5555);
        lookup(1, 10'h010, 16'hAAAA);

        // Mask zero commits nothing but still advances: bank0[0] keeps 0x3344, bank0[1]=0x6666
        gpio_wr(R_CTRL, 8'h02, 1);
        gpio_wr(R_MASK, 8'h00, 1);
        gpio_wr(R_DATA, 8'h77, 1);
        gpio_wr(R_DATA, 8'h77, 1);
        gpio_wr(R_MASK, 8'h03, 1);
        gpio_wr(R_DATA, 8'h66, 1);
        gpio_wr(R_DATA, 8'h66, 1);
        gpio_wr(R_CTRL, 8'h02, 1);
        gpio_wr(R_ADDR, 8'h05, 1);
        gpio_wr(R_DATA, 8'h00, 1);
        gpio_wr(R_DATA, 8'h01, 1);
        gpio_wr(R_CTRL, 8'h01, 1);
        check("swap4_active_bank", 32'(bus.active_bank), 32'd0);
        lookup(0, 10'h000, 16'h3344);
        lookup(1, 10'h001, 16'h6666);

        // Hitless swap: bank1[5]=0x0002 while bank0[5]=0x0001 is live
        gpio_wr(R_CTRL, 8'h02, 1);
        gpio_wr(R_ADDR, 8'h05, 1);
        gpio_wr(R_DATA, 8'h00, 1);
        gpio_wr(R_DATA, 8'h02, 1);
        bus.val_in[0 +: IN_BITS] = 10'h005;
        for (int k = 0; k < 10; k++) begin
            bus.val_in_valid[0] = 1'b1;
            push_exp(0, (k <= 4) ? 16'h0001 : 16'h0002);
            if (k == 4) bus.gpio_in = {1'b1, 15'd0, R_CTRL, 8'h01};
            if (k == 6) bus.gpio_in = {1'b0, 15'd0, R_CTRL, 8'h01};
            tick();
        end
        bus.val_in_valid[0] = 1'b0;
        repeat (4) tick();
        check("swap5_active_bank", 32'(bus.active_bank), 32'd1);

        // Long w_clk pulse: 0x12 must be accepted once, so bank0[7]=0x1234
        gpio_wr(R_CTRL, 8'h02, 1);
        gpio_wr(R_ADDR, 8'h07, 1);
        gpio_wr(R_DATA, 8'h12, 10);
        gpio_wr(R_DATA, 8'h34, 1);
        gpio_wr(R_CTRL, 8'h01, 1);
        check("swap6_active_bank", 32'(bus.active_bank), 32'd0);
        lookup(0, 10'h007, 16'h1234);

        // Reset after one data byte and with a lookup in flight
        gpio_wr(R_CTRL, 8'h01, 1);
        check("swap7_active_bank", 32'(bus.active_bank), 32'd1);
        gpio_wr(R_DATA, 8'h99, 1);
        bus.val_in[IN_BITS +: IN_BITS] = 10'h000;
        bus.val_in_valid[1] = 1'b1;
        tick();
        bus.val_in_valid[1] = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("mid_reset_active_bank", 32'(bus.active_bank), 32'd0);
        check("mid_reset_out_valid", 32'(bus.val_out_valid), 32'd0);
        check("mid_reset_val_out", 32'(bus.val_out), 32'd0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (4) tick();
        check("post_reset_active_bank", 32'(bus.active_bank), 32'd0);
        gpio_wr(R_DATA, 8'hCA, 1);
        gpio_wr(R_DATA, 8'hFE, 1);
        gpio_wr(R_CTRL, 8'h01, 1);
        check("swap8_active_bank", 32'(bus.active_bank), 32'd1);
        lookup(0, 10'h000, 16'hCAFE);

        // Drain: every expected result must have been presented
        for (int w = 0; w < 20 && (q0.size() + q1.size()) > 0; w++) tick();
        check("pending_ch0", 32'(q0.size()), 32'd0);
        check("pending_ch1", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lookup_table_mc.md
Name: lookup_table_mc

Overview:
Multi-channel, double-buffered, GPIO-programmed lookup table. It generalises the single-channel 16-bit LUT to NUM_CH independent channels, arbitrary in/out widths (multi-byte word assembly), per-channel write masking, and atomic ping-pong bank swap. Software reprograms the shadow bank while the Ising datapath keeps reading the active bank uninterrupted.

Parameters:
ADDR_REG, 0, GPIO address: LUT address byte (shifted in MSB-first)
DATA_REG, 1, GPIO address: LUT data byte (MSB-first)
CTRL_REG, 2, GPIO address: command register
CHMASK_REG, 3, GPIO address: channel write-enable mask
NUM_CH, 2, number of channels (1..8)
IN_BITS, 10, lookup address width (1..16); depth 2**IN_BITS per bank per channel
OUT_BITS, 16, output word width (1..32)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
gpio_in  in  32  GPIO bus; w_clk bit, address field and 8-bit data field decoded with the ising_config constants
val_in  in  NUM_CH*IN_BITS  lookup addresses; channel i at [i*IN_BITS +: IN_BITS]
val_in_valid  in  NUM_CH  per-channel lookup strobe
val_out  out  NUM_CH*OUT_BITS  lookup results; channel i at [i*OUT_BITS +: OUT_BITS]
val_out_valid  out  NUM_CH  per-channel result strobe
active_bank  out  1  bank currently serving lookups

Behaviour:
- Constants: AB = ceil(IN_BITS/8) address bytes; DB = ceil(OUT_BITS/8) data bytes.
- GPIO handshake: a register access executes exactly once per w_clk high pulse. FSM IDLE -> (w_clk=1, decoded addr) act, -> WAIT; WAIT -> IDLE when w_clk=0. Unknown addresses are ignored but still enter WAIT.
- ADDR_REG write: wr_addr <= {wr_addr, byte} truncated to IN_BITS; data byte count cleared.
- DATA_REG write: byte shifted into a data accumulator; byte count increments. On the DB-th byte, the low OUT_BITS of the accumulator are written to the shadow bank (!active_bank) at wr_addr for every channel whose chmask bit is 1. wr_addr then increments modulo 2**IN_BITS (2**IN_BITS-1 wraps to 0), and the count clears.
- CTRL_REG: data bit0 = swap (active_bank toggles on the next clk; the in-progress data byte count clears). Bit1 = clear wr_addr and byte count. Both bits set: swap and clear in the same cycle. Other bits are ignored.
- CHMASK_REG: chmask <= data[NUM_CH-1:0]; takes effect for the next committed word. chmask = 0 commits nothing, but wr_addr still increments.
- Lookup pipeline, per channel, independent:
  - Latency 2 clks.
  - Cycle 0: val_in_valid sampled; address and active_bank captured.
  - Cycle 2: val_out_valid=1 with the data from the captured bank.
  - Back-to-back valids give one result per clk.
  - When valid is low, val_out holds its last value and val_out_valid=0.
- Swap vs. lookup: a lookup sampled in the same cycle the swap command registers uses the old bank. The first lookup sampled after active_bank changes uses the new bank. In-flight lookups are never corrupted.
- Shadow write vs. lookup to the same address: no conflict, because writes only touch the inactive bank.
- Reset (async assert, sync release): active_bank=0, wr_addr=0, byte count=0, accumulators=0, chmask=all ones, FSM=IDLE, val_out=0, val_out_valid=0. Memory contents are not reset (undefined until programmed). Reset mid-word discards the partial word. Reset mid-pipeline drops pending valids.

Test Plan:
- Program (IN_BITS=10, OUT_BITS=16, NUM_CH=2): ADDR 0x01,0x23; DATA 0xBE,0xEF; CTRL swap; lookup ch0 addr 0x123 -> val_out ch0=0xBEEF, valid exactly 2 clks after strobe.
- Auto-increment/wrap: ADDR 0x03,0xFF; DATA 0x11,0x22,0x33,0x44; swap -> addr 0x3FF=0x1122, addr 0x000=0x3344.
- Mask: CHMASK=0x02; write 0xAAAA at 0x010; swap -> ch1 reads 0xAAAA, ch0 reads its previous value (preloaded 0x5555).
- Hitless swap: stream ch0 lookups to addr 5 every clk (bank0=0x0001, bank1=0x0002); issue swap mid-stream -> outputs switch 0x0001 to 0x0002 on a single boundary, no gap and no invalid value.
- GPIO pulse held high 10 clks with DATA_REG -> only one byte accepted; the byte count increments by 1.
- Async reset asserted after a single data byte -> active_bank=0, val_out_valid=0. After release, a full 2-byte write commits correctly with no stale byte.
